// File: rtl/bitop_pkg.sv
// Shared opcode and FSM state encodings for the bit-operation sequencer.
package bitop_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT_B = 2'b01,
    ST_EXEC   = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

endpackage

// File: rtl/bitop_alu.sv
// Combinational 8-bit bitwise ALU: OR / AND / XOR / NOR selected by op.
module bitop_alu
  import bitop_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] op,
  output logic [7:0] y
);

  always_comb begin
    y = a | b;
    unique case (op)
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = a | b;
    endcase
  end

endmodule

// File: rtl/tt_um_bitop_sequencer.sv
// Two-operand bitwise sequencer: strobe A (with opcode), strobe B, one EXEC cycle,
// then hold the registered result in DONE until acknowledged.
module tt_um_bitop_sequencer
  import bitop_pkg::*;
#(
  parameter logic [7:0] RESULT_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t     state, state_nxt;
  logic [7:0] a_q, b_q, r_q, alu_y;
  logic [1:0] op_q;
  logic       valid_q, valid_rise, ack;
  logic       cap_a, cap_b;
  logic       busy, done;
  logic       unused_ok;

  assign valid_rise = uio_in[0] & ~valid_q;
  assign ack        = uio_in[3];
  assign unused_ok  = &{1'b0, uio_in[7:4]};

  bitop_alu u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  // Abort in WAIT_B and ack in DONE both take priority over a coincident valid edge.
  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    unique case (state)
      ST_IDLE: if (valid_rise) begin
        cap_a     = 1'b1;
        state_nxt = ST_WAIT_B;
      end
      ST_WAIT_B: if (ack) begin
        state_nxt = ST_IDLE;
      end else if (valid_rise) begin
        cap_b     = 1'b1;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_DONE;
      ST_DONE: if (ack) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_OR;
      r_q     <= RESULT_RST;
      valid_q <= 1'b0;
    end else if (ena) begin
      state   <= state_nxt;
      valid_q <= uio_in[0];
      if (cap_a) begin
        a_q  <= ui_in;
        op_q <= uio_in[2:1];
      end
      if (cap_b) b_q <= ui_in;
      if (state == ST_EXEC) r_q <= alu_y;
    end
  end

  assign busy    = (state == ST_WAIT_B) || (state == ST_EXEC);
  assign done    = (state == ST_DONE);
  assign uo_out  = r_q;
  assign uio_out = {state, done, busy, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_bitop_sequencer.sv
// Directed self-checking bench for tt_um_bitop_sequencer.
module tb_tt_um_bitop_sequencer;

  localparam logic [7:0] RRST = 8'h3C;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0;
  int errors = 0;

  // uio_out expectations: {state, done, busy, 4'h0}
  localparam logic [7:0] U_IDLE = 8'h00;
  localparam logic [7:0] U_WB   = 8'h50;
  localparam logic [7:0] U_EX   = 8'h90;
  localparam logic [7:0] U_DONE = 8'hE0;

  tt_um_bitop_sequencer #(.RESULT_RST(RRST)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d, input logic [1:0] op);
    ui_in       = d;
    uio_in[2:1] = op;
    uio_in[0]   = 1'b1;
    tick();
    uio_in[0]   = 1'b0;
    tick();
  endtask

  task automatic do_ack();
    uio_in[3] = 1'b1;
    tick();
    uio_in[3] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (uo_out !== RRST) begin errors++; $display("FAIL reset_uo got %h exp %h", uo_out, RRST); end
    checks++; if (uio_out !== U_IDLE) begin errors++; $display("FAIL reset_uio got %h exp %h", uio_out, U_IDLE); end
    checks++; if (uio_oe !== 8'hF0) begin errors++; $display("FAIL reset_oe got %h exp %h", uio_oe, 8'hF0); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    strobe(8'hF0, 2'b00);
    checks++; if (uio_out !== U_WB) begin errors++; $display("FAIL basic_waitb got %h exp %h", uio_out, U_WB); end
    ui_in = 8'h0F; uio_in[0] = 1'b1;
    tick();
    checks++; if (uio_out !== U_EX) begin errors++; $display("FAIL basic_exec got %h exp %h", uio_out, U_EX); end
    checks++; if (uo_out !== RRST) begin errors++; $display("FAIL basic_exec_uo got %h exp %h", uo_out, RRST); end
    uio_in[0] = 1'b0;
    tick();
    checks++; if (uo_out !== 8'hFF) begin errors++; $display("FAIL basic_result got %h exp %h", uo_out, 8'hFF); end
    checks++; if (uio_out !== U_DONE) begin errors++; $display("FAIL basic_done got %h exp %h", uio_out, U_DONE); end
    do_ack();
    checks++; if (uio_out !== U_IDLE) begin errors++; $display("FAIL basic_ack got %h exp %h", uio_out, U_IDLE); end
    checks++; if (uo_out !== 8'hFF) begin errors++; $display("FAIL basic_ack_uo got %h exp %h", uo_out, 8'hFF); end
  endtask

  task automatic test_ops();
    logic [7:0] exp_tab [4];
    exp_tab = '{8'hEE, 8'h88, 8'h66, 8'h11};
    for (int i = 0; i < 4; i++) begin
      strobe(8'hCC, 2'(i));
      strobe(8'hAA, 2'b00);
      checks++; if (uo_out !== exp_tab[i]) begin errors++; $display("FAIL op%0d got %h exp %h", i, uo_out, exp_tab[i]); end
      tick(); tick(); tick();
      checks++; if (uo_out !== exp_tab[i]) begin errors++; $display("FAIL op%0d_hold got %h exp %h", i, uo_out, exp_tab[i]); end
      checks++; if (uio_out !== U_DONE) begin errors++; $display("FAIL op%0d_done got %h exp %h", i, uio_out, U_DONE); end
      do_ack();
    end
  endtask

  task automatic test_held_valid();
    ui_in = 8'h12; uio_in[2:1] = 2'b01; uio_in[0] = 1'b1;
    tick();
    ui_in = 8'h34;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (uio_out !== U_WB) begin errors++; $display("FAIL held_state got %h exp %h", uio_out, U_WB); end
    uio_in[0] = 1'b0;
    tick();
    // A must be 8'h12 and op AND; the B strobe's op field is ignored
    strobe(8'hFF, 2'b10);
    checks++; if (uo_out !== 8'h12) begin errors++; $display("FAIL held_result got %h exp %h", uo_out, 8'h12); end
    do_ack();
  endtask

  task automatic test_abort();
    strobe(8'h5A, 2'b00);
    strobe(8'h00, 2'b00);
    do_ack();
    strobe(8'hFF, 2'b00);
    do_ack();
    checks++; if (uio_out !== U_IDLE) begin errors++; $display("FAIL abort_state got %h exp %h", uio_out, U_IDLE); end
    checks++; if (uo_out !== 8'h5A) begin errors++; $display("FAIL abort_uo got %h exp %h", uo_out, 8'h5A); end
    strobe(8'hFF, 2'b00);
    ui_in = 8'h0F; uio_in[0] = 1'b1; uio_in[3] = 1'b1;
    tick();
    uio_in[0] = 1'b0; uio_in[3] = 1'b0;
    tick();
    checks++; if (uio_out !== U_IDLE) begin errors++; $display("FAIL abort_coinc got %h exp %h", uio_out, U_IDLE); end
    checks++; if (uo_out !== 8'h5A) begin errors++; $display("FAIL abort_coinc_uo got %h exp %h", uo_out, 8'h5A); end
  endtask

  task automatic test_reset_exec();
    strobe(8'h01, 2'b00);
    ui_in = 8'h80; uio_in[0] = 1'b1;
    tick();
    rst_n = 1'b0; uio_in[0] = 1'b0;
    tick();
    checks++; if (uio_out !== U_IDLE) begin errors++; $display("FAIL rstexec_state got %h exp %h", uio_out, U_IDLE); end
    checks++; if (uo_out !== RRST) begin errors++; $display("FAIL rstexec_uo got %h exp %h", uo_out, RRST); end
    rst_n = 1'b1;
    tick();
    checks++; if (uo_out !== RRST) begin errors++; $display("FAIL rstexec_after got %h exp %h", uo_out, RRST); end
  endtask

  task automatic test_ena();
    strobe(8'h0F, 2'b10);
    ena = 1'b0;
    ui_in = 8'hF0; uio_in[0] = 1'b1;
    tick(); tick(); tick();
    checks++; if (uio_out !== U_WB) begin errors++; $display("FAIL ena_state got %h exp %h", uio_out, U_WB); end
    checks++; if (uo_out !== RRST) begin errors++; $display("FAIL ena_uo got %h exp %h", uo_out, RRST); end
    uio_in[0] = 1'b0;
    ena = 1'b1;
    tick();
    strobe(8'hFF, 2'b00);
    checks++; if (uo_out !== 8'hF0) begin errors++; $display("FAIL ena_result got %h exp %h", uo_out, 8'hF0); end
    ena = 1'b0; uio_in[3] = 1'b1;
    tick(); tick();
    checks++; if (uio_out !== U_DONE) begin errors++; $display("FAIL ena_done_hold got %h exp %h", uio_out, U_DONE); end
    ena = 1'b1;
    tick();
    uio_in[3] = 1'b0;
    checks++; if (uio_out !== U_IDLE) begin errors++; $display("FAIL ena_resume got %h exp %h", uio_out, U_IDLE); end
  endtask

  task automatic test_done_valid();
    strobe(8'h33, 2'b01);
    strobe(8'h0F, 2'b00);
    strobe(8'hAA, 2'b00);
    checks++; if (uio_out !== U_DONE) begin errors++; $display("FAIL done_valid_state got %h exp %h", uio_out, U_DONE); end
    checks++; if (uo_out !== 8'h03) begin errors++; $display("FAIL done_valid_uo got %h exp %h", uo_out, 8'h03); end
    ui_in = 8'h55; uio_in[0] = 1'b1; uio_in[3] = 1'b1;
    tick();
    uio_in[0] = 1'b0; uio_in[3] = 1'b0;
    tick();
    checks++; if (uio_out !== U_IDLE) begin errors++; $display("FAIL done_ack_valid got %h exp %h", uio_out, U_IDLE); end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset();
    test_basic();
    test_ops();
    test_held_valid();
    test_abort();
    test_reset_exec();
    test_ena();
    test_done_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_bitop_sequencer.md
TT_UM_BITOP_SEQUENCER -- requirements
Module: tt_um_bitop_sequencer

Interface
REQ-001 Parameter: RESULT_RST, default 8'h00, value loaded into the result register on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-004 Port: ena  input  1  design-selected enable; when 0, all registers hold.
REQ-005 Port: ui_in  input  8  operand data bus (A, then B).
REQ-006 Port: uo_out  output  8  result register R.
REQ-007 Port: uio_in  input  8  [0] valid strobe, [2:1] opcode, [3] ack/abort, [7:4] unused.
REQ-008 Port: uio_out  output  8  [3:0] = 0, [4] busy, [5] done, [7:6] state code.
REQ-009 Port: uio_oe  output  8  constant 8'hF0 ([7:4] driven, [3:0] inputs).

Function
REQ-010 Opcodes SHALL be: 00 OR, 01 AND, 10 XOR, 11 NOR, applied bitwise to the 8-bit operands.
REQ-011 valid_rise SHALL be uio_in[0] & ~valid_q, where valid_q is uio_in[0] registered each enabled cycle.
REQ-012 States SHALL be IDLE(00), WAIT_B(01), EXEC(10), DONE(11); the state code is driven on uio_out[7:6].
REQ-013 In IDLE, valid_rise SHALL capture ui_in into A and uio_in[2:1] into OP, then go to WAIT_B.
REQ-014 In WAIT_B, valid_rise SHALL capture ui_in into B, then go to EXEC; the opcode is not re-sampled.
REQ-015 In WAIT_B, ack=1 SHALL abort to IDLE with R unchanged; if valid_rise and ack coincide, abort wins.
REQ-016 EXEC SHALL last exactly one cycle: R <= f(A,B,OP), next state DONE.
REQ-017 uo_out SHALL equal R directly (registered); the new result is visible on the first DONE cycle, 2 cycles after the B strobe edge.
REQ-018 In DONE, done=1 SHALL hold until ack=1, then go to IDLE; valid_rise in DONE is ignored, including when it coincides with ack.
REQ-019 busy SHALL be 1 in WAIT_B and EXEC and 0 otherwise; done SHALL be 1 only in DONE.
REQ-020 R SHALL change only in EXEC or at reset; A, B and OP SHALL change only on their capture events or at reset.
REQ-021 A held-high valid SHALL produce exactly one capture; a new capture requires valid to return low first.
REQ-022 With ena=0, the state, A, B, OP, R and valid_q SHALL all hold, and outputs stay stable.

Reset
REQ-023 When rst_n=0 at a clock edge, the block SHALL set state=IDLE, A=B=0, OP=00, valid_q=0 and R=RESULT_RST, regardless of ena.
REQ-024 Reset asserted mid-operation (WAIT_B, EXEC or DONE) SHALL discard the operation, with no R update on the following cycle.
REQ-025 Outputs out of reset SHALL be: uo_out=RESULT_RST, uio_out=8'h00, uio_oe=8'hF0.

Structure
REQ-026 A shared package bitop_pkg SHALL hold the opcode localparams (OP_OR, OP_AND, OP_XOR, OP_NOR) and the state encodings.
REQ-027 Combinational sub-module bitop_alu (a, b, op -> y) SHALL implement REQ-010 and be instantiated once.
REQ-028 The top level SHALL contain only the FSM, the registers, the edge detect and the output mapping; no latches and no combinational paths from uio_in to uo_out.

Verification
REQ-029 Reset, then strobe A=8'hF0 op=00, strobe B=8'h0F -> uo_out=8'hFF with done=1 two cycles after the B edge; ack -> IDLE, uio_out[7:6]=00.
REQ-030 Run A=8'hCC/B=8'hAA for each opcode -> 8'hEE, 8'h88, 8'h66, 8'h11, and uo_out holds each value through DONE.
REQ-031 Keep valid high for 5 cycles in IDLE -> only A is captured and the state remains WAIT_B (busy=1).
REQ-032 After a prior result of 8'h5A, capture A then assert ack in WAIT_B (also together with a valid edge) -> IDLE, uo_out stays 8'h5A.
REQ-033 Assert rst_n=0 for one cycle in EXEC -> next cycle state=IDLE and uo_out=RESULT_RST; with ena=0 mid-sequence, all outputs frozen until ena=1.
REQ-034 In DONE, a valid edge without ack -> no state change; ack and a valid edge together -> IDLE with no capture.
